word_serializer: RTL

Transmit-path serializer that accepts 32-bit words on a valid/ready handshake, buffers them in a small FIFO, and emits each word as a 5-cycle byte frame. The frame is a start strobe with a lead byte, followed by the four data bytes MSB first. It sits directly upstream of the 4-byte-to-32-bit deserializer and drives that block's Cin/Din inputs. Back-to-back frames are sent with no idle cycles while the FIFO holds data.

---
 rtl/word_serializer.sv | 113 +++++++++++
 1 files changed

// File: rtl/word_serializer.sv
// Transmit serializer: queues 32-bit words in a small FIFO and emits each as a
// 5-cycle frame (strobe + lead byte, then data bytes MSB first).
//
// state | meaning
// IDLE  | no frame in progress, waiting for a queued word
// LEAD  | strobe cycle, Cout=1, Dout=LEAD_BYTE
// B3    | Dout = word[31:24]
// B2    | Dout = word[23:16]
// B1    | Dout = word[15:8]
// B0    | Dout = word[7:0], next frame starts here if FIFO non-empty
module word_serializer #(
  parameter int          DEPTH     = 4,
  parameter logic [7:0]  LEAD_BYTE = 8'h00
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  input  logic [31:0]                  in_data,
  output logic                         in_ready,
  output logic                         Cout,
  output logic [7:0]                   Dout,
  output logic                         busy,
  output logic [$clog2(DEPTH+1)-1:0]   fifo_level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH+1);

  typedef enum logic [2:0] {IDLE, LEAD, B3, B2, B1, B0} state_t;

  state_t          state_q, state_d;
  logic [31:0]     mem [DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [31:0]     word_q;
  logic            push, pop, fifo_nonempty;
  logic            cout_d;
  logic [7:0]      dout_d;

  assign in_ready      = (fifo_level != LW'(DEPTH));
  assign push          = in_valid && in_ready;
  assign fifo_nonempty = (fifo_level != '0);

  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    cout_d  = 1'b0;
    dout_d  = 8'h00;
    case (state_q)
      IDLE: if (fifo_nonempty) begin
        state_d = LEAD;
        pop     = 1'b1;
      end
      LEAD: state_d = B3;
      B3:   state_d = B2;
      B2:   state_d = B1;
      B1:   state_d = B0;
      B0: begin
        if (fifo_nonempty) begin
          state_d = LEAD;
          pop     = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    // Output bytes are chosen by the state being entered so Dout is registered.
    case (state_d)
      LEAD: begin
        cout_d = 1'b1;
        dout_d = LEAD_BYTE;
      end
      B3:      dout_d = word_q[31:24];
      B2:      dout_d = word_q[23:16];
      B1:      dout_d = word_q[15:8];
      B0:      dout_d = word_q[7:0];
      default: dout_d = 8'h00;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      Cout       <= 1'b0;
      Dout       <= 8'h00;
      busy       <= 1'b0;
      word_q     <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
    end else begin
      state_q <= state_d;
      Cout    <= cout_d;
      Dout    <= dout_d;
      busy    <= (state_d != IDLE);
      if (pop) begin
        word_q <= mem[rd_ptr];
        rd_ptr <= rd_ptr + AW'(1);
      end
      if (push) wr_ptr <= wr_ptr + AW'(1);
      case ({push, pop})
        2'b10:   fifo_level <= fifo_level + LW'(1);
        2'b01:   fifo_level <= fifo_level - LW'(1);
        default: fifo_level <= fifo_level;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_data;
  end

endmodule
